// File: rtl/acumulador_bloque.sv
// Block accumulator: sums N_MUESTRAS signed samples with saturation
// and hands each block sum downstream over a valid/ready port.
module acumulador_bloque #(
    parameter int IN_W       = 5,
    parameter int ACC_W      = 8,
    parameter int N_MUESTRAS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(N_MUESTRAS + 1);
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(N_MUESTRAS);

    typedef enum logic {
        ACUM,
        SALIDA
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             dovf_q, dovf_d;

    logic [ACC_W:0]   suma;
    logic [ACC_W-1:0] acc_sat;
    logic             sat;
    logic [CNT_W-1:0] cnt_inc;

    // ACC_W+1 bits cannot overflow, so a mismatch of the top two bits
    // means the ACC_W-bit result is out of range.
    assign suma = {{(ACC_W + 1 - IN_W){in_data[IN_W-1]}}, in_data}
                + {acc_q[ACC_W-1], acc_q};
    assign sat  = suma[ACC_W] ^ suma[ACC_W-1];
    assign acc_sat = !sat ? suma[ACC_W-1:0]
                   : suma[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                   : {1'b0, {(ACC_W - 1){1'b1}}};
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        estado_d = estado_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        dout_d   = dout_q;
        dovf_d   = dovf_q;
        if (clear) begin
            estado_d = ACUM;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            case (estado_q)
                ACUM: begin
                    if (in_valid) begin
                        if (cnt_inc == CNT_FIN) begin
                            dout_d   = acc_sat;
                            dovf_d   = ovf_q | sat;
                            acc_d    = '0;
                            cnt_d    = '0;
                            ovf_d    = 1'b0;
                            estado_d = SALIDA;
                        end else begin
                            acc_d = acc_sat;
                            cnt_d = cnt_inc;
                            ovf_d = ovf_q | sat;
                        end
                    end
                end
                SALIDA: begin
                    if (out_ready) estado_d = ACUM;
                end
                default: estado_d = ACUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= ACUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
            dovf_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            dovf_q   <= dovf_d;
        end
    end

    assign in_ready  = (estado_q == ACUM);
    assign out_valid = (estado_q == SALIDA);
    assign out_data  = dout_q;
    assign out_ovf   = dovf_q;

endmodule

// File: tb/tb_acumulador_bloque.sv
// Directed bench for acumulador_bloque: 8-bit, 6-bit and
// single-sample instances driven from a shared stimulus.
module tb_acumulador_bloque;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_data;
    logic       clear;
    logic       out_ready;

    logic       ir8, ov8, ovf8;
    logic [7:0] od8;
    logic       ir6, ov6, ovf6;
    logic [5:0] od6;
    logic       ir1, ov1, ovf1;
    logic [7:0] od1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    acumulador_bloque #(.IN_W(5), .ACC_W(8), .N_MUESTRAS(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .in_data(in_data), .clear(clear), .out_valid(ov8),
        .out_ready(out_ready), .out_data(od8), .out_ovf(ovf8));

    acumulador_bloque #(.IN_W(5), .ACC_W(6), .N_MUESTRAS(4)) u6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir6),
        .in_data(in_data), .clear(clear), .out_valid(ov6),
        .out_ready(out_ready), .out_data(od6), .out_ovf(ovf6));

    acumulador_bloque #(.IN_W(5), .ACC_W(8), .N_MUESTRAS(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .clear(clear), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1), .out_ovf(ovf1));

    typedef struct {
        logic       v;
        logic [4:0] d;
        logic       clr;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] d,
                        input logic clr, input logic ordy);
        in_valid  = v;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic add(input logic v, input logic [4:0] d, input logic clr,
                       input logic ordy, input logic ir, input logic ov,
                       input logic [7:0] od, input logic ovf);
        vec_t t;
        t.v = v; t.d = d; t.clr = clr; t.ordy = ordy;
        t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_ovf = ovf;
        tbl.push_back(t);
    endtask

    task automatic blk6(input logic [4:0] d, input logic [5:0] e_od,
                        input logic e_ovf, input string name);
        for (int i = 0; i < 4; i++) step(1'b1, d, 1'b0, 1'b0);
        chk({name, "_ov"}, {31'd0, ov6}, 32'd1);
        chk({name, "_od"}, {26'd0, od6}, {26'd0, e_od});
        chk({name, "_ovf"}, {31'd0, ovf6}, {31'd0, e_ovf});
        step(1'b0, 5'd0, 1'b0, 1'b1);
        chk({name, "_ir"}, {31'd0, ir6}, 32'd1);
    endtask

    initial begin
        int acc_n;
        int cyc;
        logic pre_ir;

        in_valid = 0; in_data = 0; clear = 0; out_ready = 0;
        do_reset();
        chk("rst_ir", {31'd0, ir8}, 32'd1);
        chk("rst_ov", {31'd0, ov8}, 32'd0);
        chk("rst_od", {24'd0, od8}, 32'd0);
        chk("rst_ovf", {31'd0, ovf8}, 32'd0);

        // basic sum 3,-2,7,1 = 9
        add(1, 5'd3,  0, 1, 1, 0, 8'd0, 0);
        add(1, 5'h1E, 0, 1, 1, 0, 8'd0, 0);
        add(1, 5'd7,  0, 1, 1, 0, 8'd0, 0);
        add(1, 5'd1,  0, 1, 0, 1, 8'd9, 0);
        add(0, 5'd0,  0, 1, 1, 0, 8'd9, 0);
        // backpressure for 5 cycles, offered samples ignored
        add(1, 5'd3,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'h1E, 0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd7,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd1,  0, 0, 0, 1, 8'd9, 0);
        for (int i = 0; i < 5; i++) add(1, 5'd7, 0, 0, 0, 1, 8'd9, 0);
        add(0, 5'd0,  0, 1, 1, 0, 8'd9, 0);
        // abort: 5,5 then clear with sample 5, then 1 x4
        add(1, 5'd5,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd5,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd5,  1, 0, 1, 0, 8'd9, 0);
        add(1, 5'd1,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd1,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd1,  0, 0, 1, 0, 8'd9, 0);
        add(1, 5'd1,  0, 0, 0, 1, 8'd4, 0);
        add(0, 5'd0,  0, 1, 1, 0, 8'd4, 0);
        // clear while in SALIDA drops out_valid, keeps data
        for (int i = 0; i < 3; i++) add(1, 5'd2, 0, 0, 1, 0, 8'd4, 0);
        add(1, 5'd2,  0, 0, 0, 1, 8'd8, 0);
        add(0, 5'd0,  1, 0, 1, 0, 8'd8, 0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy);
            chk($sformatf("v%0d_ir", i), {31'd0, ir8}, {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d_ov", i), {31'd0, ov8}, {31'd0, tbl[i].e_ov});
            chk($sformatf("v%0d_od", i), {24'd0, od8}, {24'd0, tbl[i].e_od});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf8}, {31'd0, tbl[i].e_ovf});
        end

        // rst mid-block after two samples
        step(1, 5'd3, 0, 0);
        step(1, 5'd3, 0, 0);
        rst = 1'b1;
        step(1, 5'd3, 1, 1);
        rst = 1'b0;
        chk("midrst_ir", {31'd0, ir8}, 32'd1);
        chk("midrst_ov", {31'd0, ov8}, 32'd0);
        chk("midrst_od", {24'd0, od8}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf8}, 32'd0);
        for (int i = 0; i < 4; i++) step(1, 5'd1, 0, 0);
        chk("postrst_od", {24'd0, od8}, 32'd4);

        // saturation on the 6-bit instance
        do_reset();
        blk6(5'd15, 6'd31, 1'b1, "satpos");
        blk6(5'h10, 6'b100000, 1'b1, "satneg");
        blk6(5'd1, 6'd4, 1'b0, "nosticky");

        // gapped input of -1 x4
        do_reset();
        acc_n = 0;
        cyc = 0;
        while (acc_n < 4 && cyc < 100) begin
            pre_ir = ir8;
            step(1'($urandom_range(0, 1)), 5'h1F, 0, 0);
            if (in_valid && pre_ir) acc_n++;
            cyc++;
            chk("gap_ov", {31'd0, ov8}, {31'd0, acc_n == 4});
        end
        chk("gap_done", {31'd0, acc_n == 4}, 32'd1);
        chk("gap_od", {24'd0, od8}, 32'hFC);
        chk("gap_ovf", {31'd0, ovf8}, 32'd0);

        // single-sample blocks
        do_reset();
        step(1, 5'd3, 0, 0);
        chk("n1_ov", {31'd0, ov1}, 32'd1);
        chk("n1_od", {24'd0, od1}, 32'd3);
        step(1, 5'd5, 0, 0);
        chk("n1_hold_od", {24'd0, od1}, 32'd3);
        chk("n1_hold_ir", {31'd0, ir1}, 32'd0);
        step(0, 5'd0, 0, 1);
        chk("n1_rel_ov", {31'd0, ov1}, 32'd0);
        chk("n1_rel_ir", {31'd0, ir1}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
